// File: rtl/vmx_tile_sequencer.sv
// rtl/vmx_tile_sequencer.sv - weight/vector sequencer with input skew and output deskew for a systolic PE array
module vmx_tile_sequencer #(
    parameter int PE_SIZE = 4,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int PE_LAT  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [ADDR_W-1:0]             rbase,
    input  logic [ADDR_W-1:0]             wbase,
    input  logic [ADDR_W-1:0]             n_vec,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [2:0]                    state,
    output logic                          rd_en,
    output logic [ADDR_W-1:0]             rd_addr,
    input  logic [DATA_W*PE_SIZE-1:0]     rd_data,
    output logic                          wr_en,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic [2*DATA_W*PE_SIZE-1:0]   wr_data,
    output logic                          pe_clr_n,
    output logic [8*PE_SIZE-1:0]          pe_is_weight,
    output logic [DATA_W*PE_SIZE-1:0]     pe_vector,
    input  logic [2*DATA_W*PE_SIZE-1:0]   pe_product
);
    localparam int VD = PE_SIZE + PE_LAT + 1;
    localparam int PW = 2 * DATA_W;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WGHT  = 3'd1,
        S_STRM  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            st_q, st_d;
    logic [ADDR_W-1:0] rbase_q, wbase_q, nvec_q, cnt_q, wr_cnt_q;
    logic              err_q, clr_n_q, go, last_wr;
    logic [VD-1:0]     vpipe;
    logic [7:0]        tag_nxt;
    logic [7:0]        tag_line [0:PE_SIZE];

    assign go      = (st_q == S_IDLE) && start && !abort && (n_vec != '0);
    assign wr_en   = vpipe[VD-1];
    assign last_wr = wr_en && (wr_cnt_q == nvec_q - ADDR_W'(1));

    always_comb begin
        st_d  = st_q;
        rd_en = 1'b0;
        if (abort) begin
            st_d = S_IDLE;
        end else begin
            case (st_q)
                S_IDLE:  if (go) st_d = S_WGHT;
                S_WGHT: begin
                    rd_en = 1'b1;
                    if (cnt_q == ADDR_W'(PE_SIZE - 1)) st_d = S_STRM;
                end
                S_STRM: begin
                    rd_en = 1'b1;
                    if (cnt_q == nvec_q - ADDR_W'(1)) st_d = S_DRAIN;
                end
                S_DRAIN: if (last_wr) st_d = S_DONE;
                S_DONE:  st_d = S_IDLE;
                default: st_d = S_IDLE;
            endcase
        end
    end

    // Vector j reads rbase+PE_SIZE+j; all sums wrap at ADDR_W bits.
    assign rd_addr  = !rd_en ? '0 :
                      (st_q == S_STRM) ? rbase_q + cnt_q + ADDR_W'(PE_SIZE) : rbase_q + cnt_q;
    assign tag_nxt  = rd_en ? {(st_q == S_WGHT), 7'(cnt_q)} : 8'h00;
    assign wr_addr  = wbase_q + wr_cnt_q;
    assign busy     = (st_q != S_IDLE);
    assign done     = (st_q == S_DONE);
    assign err      = err_q;
    assign state    = st_q;
    assign pe_clr_n = clr_n_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q     <= S_IDLE;
            rbase_q  <= '0;
            wbase_q  <= '0;
            nvec_q   <= '0;
            cnt_q    <= '0;
            wr_cnt_q <= '0;
            err_q    <= 1'b0;
            clr_n_q  <= 1'b0;
            vpipe    <= '0;
            for (int m = 0; m <= PE_SIZE; m++) tag_line[m] <= '0;
        end else begin
            st_q    <= st_d;
            err_q   <= (st_q == S_IDLE) && start && !abort && (n_vec == '0);
            clr_n_q <= !(abort || go);
            if (go) begin
                rbase_q <= rbase;
                wbase_q <= wbase;
                nvec_q  <= n_vec;
            end
            if (st_d != st_q)  cnt_q <= '0;
            else if (rd_en)    cnt_q <= cnt_q + ADDR_W'(1);
            if (go || abort)   wr_cnt_q <= '0;
            else if (wr_en)    wr_cnt_q <= wr_cnt_q + ADDR_W'(1);
            if (abort) begin
                vpipe <= '0;
                for (int m = 0; m <= PE_SIZE; m++) tag_line[m] <= '0;
            end else begin
                vpipe       <= {vpipe[VD-2:0], (st_q == S_STRM)};
                tag_line[0] <= tag_nxt;
                for (int m = 1; m <= PE_SIZE; m++) tag_line[m] <= tag_line[m-1];
            end
        end
    end

    for (genvar k = 0; k < PE_SIZE; k++) begin : g_lane
        logic [DATA_W-1:0] sk [0:k];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n || abort) begin
                for (int m = 0; m <= k; m++) sk[m] <= '0;
            end else begin
                sk[0] <= rd_data[k*DATA_W +: DATA_W];
                for (int m = 1; m <= k; m++) sk[m] <= sk[m-1];
            end
        end

        assign pe_vector[k*DATA_W +: DATA_W] = sk[k];
        assign pe_is_weight[k*8 +: 8]        = tag_line[k+1];

        // The last lane leaves the array last, so it needs no deskew delay.
        if (k == PE_SIZE - 1) begin : g_nodly
            assign wr_data[k*PW +: PW] = wr_en ? pe_product[k*PW +: PW] : '0;
        end else begin : g_dly
            logic [PW-1:0] ds [0:PE_SIZE-2-k];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n || abort) begin
                    for (int m = 0; m <= PE_SIZE - 2 - k; m++) ds[m] <= '0;
                end else begin
                    ds[0] <= pe_product[k*PW +: PW];
                    for (int m = 1; m <= PE_SIZE - 2 - k; m++) ds[m] <= ds[m-1];
                end
            end

            assign wr_data[k*PW +: PW] = wr_en ? ds[PE_SIZE-2-k] : '0;
        end
    end
endmodule

// File: tb/tb_vmx_tile_sequencer.sv
// tb/tb_vmx_tile_sequencer.sv - scoreboard bench with buffer memory and lane-wise PE array model
module tb_vmx_tile_sequencer;
    localparam int PE_SIZE = 4;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 8;
    localparam int PE_LAT  = 4;
    localparam int PW      = 2 * DATA_W;

    logic clk = 0, rst_n = 0, start = 0, abort = 0;
    logic [ADDR_W-1:0] rbase = 0, wbase = 0, n_vec = 0;
    logic busy, done, err, rd_en, wr_en, pe_clr_n;
    logic [2:0] state;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [DATA_W*PE_SIZE-1:0] rd_data = '0, pe_vector;
    logic [PW*PE_SIZE-1:0] wr_data, pe_product;
    logic [8*PE_SIZE-1:0] pe_is_weight;

    vmx_tile_sequencer #(.PE_SIZE(PE_SIZE), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PE_LAT(PE_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .rbase(rbase), .wbase(wbase), .n_vec(n_vec),
        .busy(busy), .done(done), .err(err), .state(state),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pe_clr_n(pe_clr_n), .pe_is_weight(pe_is_weight),
        .pe_vector(pe_vector), .pe_product(pe_product)
    );

    always #5 clk = ~clk;

    // Buffer memory (1-clock read) and a lane-wise PE array computing 2*input after PE_LAT clocks.
    logic [DATA_W*PE_SIZE-1:0] mem [0:255];
    logic [PW*PE_SIZE-1:0] ppipe [0:PE_LAT-1];

    function automatic logic [PW*PE_SIZE-1:0] scale(input logic [DATA_W*PE_SIZE-1:0] v);
        logic [PW*PE_SIZE-1:0] r;
        for (int k = 0; k < PE_SIZE; k++) r[k*PW +: PW] = PW'(v[k*DATA_W +: DATA_W]) * 2;
        return r;
    endfunction

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        ppipe[0] <= scale(pe_vector);
        for (int i = 1; i < PE_LAT; i++) ppipe[i] <= ppipe[i-1];
    end
    assign pe_product = ppipe[PE_LAT-1];

    typedef struct {
        logic [ADDR_W-1:0]      addr;
        logic [PW*PE_SIZE-1:0]  data;
    } wr_t;
    wr_t               exp_wr[$];
    logic [ADDR_W-1:0] exp_rd[$];

    int n_pass = 0, n_total = 0, done_cnt = 0, err_cnt = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every strobe presented by the DUT is matched against the scoreboard queues.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (rst_n) begin
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (rd_en) begin
                check("rd_pending", exp_rd.size() != 0, 1);
                if (exp_rd.size() != 0) check("rd_addr", rd_addr, exp_rd.pop_front());
            end
            if (wr_en) begin
                check("wr_pending", exp_wr.size() != 0, 1);
                if (exp_wr.size() != 0) begin
                    e = exp_wr.pop_front();
                    check("wr_addr", wr_addr, e.addr);
                    check("wr_data", wr_data, e.data);
                end
            end
        end
    end

    task automatic push_job(input logic [7:0] rb, input logic [7:0] wb, input logic [7:0] nv);
        wr_t w;
        for (int i = 0; i < PE_SIZE; i++) exp_rd.push_back(rb + 8'(i));
        for (int j = 0; j < int'(nv); j++) begin
            exp_rd.push_back(rb + 8'(PE_SIZE + j));
            w.addr = wb + 8'(j);
            w.data = scale(mem[rb + 8'(PE_SIZE + j)]);
            exp_wr.push_back(w);
        end
    endtask

    task automatic flush();
        exp_rd.delete();
        exp_wr.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            @(negedge clk);
            seen = done;
        end
        check({tag, "_done_seen"}, seen, 1);
        tick();
        check({tag, "_drained"}, exp_wr.size(), 0);
    endtask

    function automatic int state_exp(input int rel, input int ab);
        if (ab >= 0 && rel > ab) return 0;
        if (rel >= 1 && rel <= 4)  return 1;
        if (rel >= 5 && rel <= 7)  return 2;
        if (rel >= 8 && rel <= 16) return 3;
        if (rel == 17)             return 4;
        return 0;
    endfunction

    // Reference job: rbase=0x10, wbase=0x80, n_vec=3, optionally aborted in cycle ab.
    task automatic scen1(input int ab);
        int se;
        rbase = 8'h10; wbase = 8'h80; n_vec = 8'd3;
        push_job(rbase, wbase, n_vec);
        start = 1;
        for (int rel = 0; rel <= 22; rel++) begin
            @(negedge clk);
            se = state_exp(rel, ab);
            check($sformatf("s1_state@%0d", rel), state, se);
            check($sformatf("s1_busy@%0d", rel), busy, se != 0);
            check($sformatf("s1_rd_en@%0d", rel), rd_en, se == 1 || se == 2);
            check($sformatf("s1_wr_en@%0d", rel), wr_en, ab < 0 && rel >= 14 && rel <= 16);
            check($sformatf("s1_done@%0d", rel), done, se == 4);
            check($sformatf("s1_clr_n@%0d", rel), pe_clr_n, !(rel == 1 || (ab >= 0 && rel == ab + 1)));
            if (ab < 0) begin
                if (rel == 14) check("s1_wr_word0", wr_data, {32'd8, 32'd6, 32'd4, 32'd2});
                for (int k = 0; k < PE_SIZE; k++) begin
                    if (rel == k + 3) check($sformatf("wtag_lane%0d", k), pe_is_weight[k*8 +: 8], 8'h80);
                    if (rel == k + 7) begin
                        check($sformatf("skew_lane%0d", k), pe_vector[k*DATA_W +: DATA_W], k + 1);
                        check($sformatf("vflag_lane%0d", k), pe_is_weight[k*8+7], 0);
                    end
                end
            end
            tick();
            if (rel == 0) start = 0;
            if (ab >= 0 && rel == ab - 1) abort = 1;
            if (ab >= 0 && rel == ab) begin
                abort = 0;
                flush();
            end
        end
        check("s1_drained", exp_wr.size(), 0);
    endtask

    initial begin
        int d0, e0, r;
        logic [7:0] rb, wb, nv;
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
        for (int i = 0; i < PE_LAT; i++) ppipe[i] = '0;
        mem[8'h14] = 64'h0004_0003_0002_0001;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_state", state, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_clr_n", pe_clr_n, 0);
        check("rst_outs", {done, err, rd_addr, wr_addr, pe_vector, pe_is_weight}, 0);
        check("rst_wr_data", wr_data, 0);
        rst_n = 1;
        tick(); tick();

        d0 = done_cnt;
        scen1(-1);
        check("s1_one_done", done_cnt - d0, 1);

        e0 = err_cnt;
        n_vec = 0; start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("nvec0_busy", busy, 0);
            tick();
        end
        check("nvec0_err_pulses", err_cnt - e0, 1);

        n_vec = 8'd2; start = 1; abort = 1;
        tick();
        start = 0; abort = 0;
        @(negedge clk);
        check("abort_beats_start", busy, 0);
        check("abort_clr_pulse", pe_clr_n, 0);
        tick();

        d0 = done_cnt;
        scen1(9);
        check("abort_no_done", done_cnt - d0, 0);
        repeat (10) tick();
        d0 = done_cnt;
        scen1(-1);
        check("restart_done", done_cnt - d0, 1);

        rbase = 8'hFD; wbase = 8'hFF; n_vec = 8'd2;
        push_job(rbase, wbase, n_vec);
        start = 1;
        tick();
        start = 0;
        wait_done("wrap");

        d0 = done_cnt;
        rbase = 8'($urandom); wbase = 8'($urandom); n_vec = 8'd3;
        push_job(rbase, wbase, n_vec);
        push_job(rbase, wbase, n_vec);
        start = 1;
        begin
            bit seen = 0;
            for (int k = 0; k < 200 && !seen; k++) begin
                @(negedge clk);
                seen = done;
            end
            check("held_first_done", seen, 1);
        end
        tick();
        @(negedge clk);
        check("held_idle_gap", busy, 0);
        tick();
        start = 0;
        @(negedge clk);
        check("held_second_start", state, 1);
        wait_done("held");
        check("held_two_jobs", done_cnt - d0, 2);

        for (int it = 0; it < 10; it++) begin
            rb = 8'($urandom); wb = 8'($urandom); nv = 8'($urandom_range(1, 12));
            rbase = rb; wbase = wb; n_vec = nv;
            push_job(rb, wb, nv);
            start = 1;
            tick();
            start = 0;
            if ($urandom_range(0, 3) == 0) begin
                r = $urandom_range(0, 12 + int'(nv));
                repeat (r) tick();
                abort = 1;
                tick();
                abort = 0;
                flush();
                repeat (14) tick();
                check("rand_abort_idle", busy, 0);
            end else begin
                wait_done("rand");
            end
        end

        rbase = 8'h20; wbase = 8'h40; n_vec = 8'd5;
        push_job(rbase, wbase, n_vec);
        start = 1;
        tick();
        start = 0;
        repeat (5) tick();
        rst_n = 0;
        #1;
        check("midrst_state", state, 0);
        check("midrst_strobes", {busy, done, err, rd_en, wr_en, pe_clr_n}, 0);
        check("midrst_data", {rd_addr, wr_addr, pe_vector, pe_is_weight}, 0);
        check("midrst_wr_data", wr_data, 0);
        flush();
        tick();
        rst_n = 1;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
